assert_change_window_gen: RTL and testbench

- Producer side of the assert_change PSL binding: generates the window, window_close and start-qualification signals that the bound assert/assume/cover units consume, and flags violations natively in RTL.
- After start_event, tracks a num_cks-cycle window in which test_expr must change.
- Handles the three new-start policies.
- Instantiated inside the assert_change wrapper alongside the PSL vunit modules.

---
 rtl/assert_change_pkg.sv | 13 +
 rtl/ovl_window_counter.sv | 29 ++
 rtl/assert_change_window_gen.sv | 138 +++++++++++++
 tb/tb_assert_change_window_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/assert_change_pkg.sv
// Shared constants and state type for the assert_change checker family.
package assert_change_pkg;

  localparam int OVL_IGNORE_NEW_START   = 0;
  localparam int OVL_RESET_ON_NEW_START = 1;
  localparam int OVL_ERROR_ON_NEW_START = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } win_state_t;

endpackage

// File: rtl/ovl_window_counter.sv
// Loadable, saturating down-counter with a terminal-count flag.
// It is shared by window-based checkers to measure the remaining cycles of a window.
module ovl_window_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; the count sticks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/assert_change_window_gen.sv
// Window generator for assert_change: opens a num_cks-cycle window on start_event,
// and closes it when test_expr changes or the window times out. It also flags violations.
module assert_change_window_gen
  import assert_change_pkg::*;
#(
  parameter int width               = 8,
  parameter int num_cks             = 2,
  parameter int action_on_new_start = OVL_IGNORE_NEW_START
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start_event,
  input  logic [width-1:0] test_expr,
  input  logic             xzcheck_enable,
  output logic             window,
  output logic             window_close,
  output logic             ignore_new_start,
  output logic             reset_on_new_start,
  output logic             error_on_new_start,
  output logic             fire_change,
  output logic             fire_new_start,
  output logic             fire_xz,
  output logic             cover_restart
);

  localparam int               CNT_W = $clog2(num_cks + 1);
  // The counter holds the cycles left after the current one, so zero marks the last window cycle.
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(num_cks - 1);

  win_state_t       state, state_n;
  logic [width-1:0] ref_expr;
  logic             load, dec, ref_load, tc;
  logic             start_q, change, xz_start, xz_expr;
  logic             window_n, close_n, fire_change_n, fire_new_start_n, fire_xz_n, cover_restart_n;

  assign ignore_new_start   = (action_on_new_start == OVL_IGNORE_NEW_START);
  assign reset_on_new_start = (action_on_new_start == OVL_RESET_ON_NEW_START);
  assign error_on_new_start = (action_on_new_start == OVL_ERROR_ON_NEW_START);

`ifdef SYNTHESIS
  assign xz_start = 1'b0;
  assign xz_expr  = 1'b0;
`else
  assign xz_start = xzcheck_enable && $isunknown(start_event);
  assign xz_expr  = xzcheck_enable && $isunknown(test_expr);
`endif

  // An unknown cycle counts as neither a start nor a change.
  assign start_q = start_event && !xz_start;
  assign change  = (test_expr != ref_expr) && !xz_expr;

  ovl_window_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (load),
    .load_val (LAST),
    .dec      (dec),
    .tc       (tc)
  );

  always_comb begin
    state_n          = state;
    load             = 1'b0;
    dec              = 1'b0;
    ref_load         = 1'b0;
    window_n         = window;
    close_n          = 1'b0;
    fire_change_n    = 1'b0;
    fire_new_start_n = 1'b0;
    fire_xz_n        = 1'b0;
    cover_restart_n  = 1'b0;
    if (enable) begin
      fire_xz_n = xz_start || ((state == OPEN) && xz_expr);
      case (state)
        IDLE: begin
          if (start_q) begin
            state_n  = OPEN;
            load     = 1'b1;
            ref_load = 1'b1;
          end
        end
        OPEN: begin
          dec = 1'b1;
          if (change || tc) begin
            // The current window resolves first. In RESET mode a coincident start reopens the window at once.
            close_n       = 1'b1;
            fire_change_n = !change;
            state_n       = IDLE;
            if (start_q && reset_on_new_start) begin
              state_n  = OPEN;
              load     = 1'b1;
              ref_load = 1'b1;
            end
          end else if (start_q) begin
            if (reset_on_new_start) begin
              load            = 1'b1;
              ref_load        = 1'b1;
              cover_restart_n = 1'b1;
            end
            if (error_on_new_start) begin
              fire_new_start_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
      window_n = (state_n == OPEN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ref_expr       <= '0;
      window         <= 1'b0;
      window_close   <= 1'b0;
      fire_change    <= 1'b0;
      fire_new_start <= 1'b0;
      fire_xz        <= 1'b0;
      cover_restart  <= 1'b0;
    end else begin
      state          <= state_n;
      if (ref_load) begin
        ref_expr <= test_expr;
      end
      window         <= window_n;
      window_close   <= close_n;
      fire_change    <= fire_change_n;
      fire_new_start <= fire_new_start_n;
      fire_xz        <= fire_xz_n;
      cover_restart  <= cover_restart_n;
    end
  end

endmodule

// File: tb/tb_assert_change_window_gen.sv
// Self-checking bench: three instances (IGNORE/RESET/ERROR) share stimulus and are
// compared every cycle against a window-age model, plus literal directed expectations.
module tb_assert_change_window_gen;
  import assert_change_pkg::*;

  localparam int W   = 8;
  localparam int NCK = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, enable, start_event, xzcheck_enable;
  logic [W-1:0] test_expr;

  logic [2:0] d_win, d_cls, d_ign, d_rst, d_err, d_fch, d_fns, d_fxz, d_crs;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assert_change_window_gen #(
      .width               (W),
      .num_cks             (NCK),
      .action_on_new_start (g)
    ) u_dut (
      .clk                (clk),
      .reset              (reset),
      .enable             (enable),
      .start_event        (start_event),
      .test_expr          (test_expr),
      .xzcheck_enable     (xzcheck_enable),
      .window             (d_win[g]),
      .window_close       (d_cls[g]),
      .ignore_new_start   (d_ign[g]),
      .reset_on_new_start (d_rst[g]),
      .error_on_new_start (d_err[g]),
      .fire_change        (d_fch[g]),
      .fire_new_start     (d_fns[g]),
      .fire_xz            (d_fxz[g]),
      .cover_restart      (d_crs[g])
    );
  end

  int total = 0;
  int bad   = 0;

  // Model: per mode, whether a window is open, its reference value and how many
  // enabled window cycles have been evaluated since it opened.
  logic [2:0]   m_open;
  logic [W-1:0] m_ref [3];
  int           m_age [3];
  logic [2:0]   e_win, e_cls, e_fch, e_fns, e_fxz, e_crs;

  task automatic model_step();
    logic xs, xe, s, chg;
    for (int m = 0; m < 3; m++) begin
      if (reset === 1'b1) begin
        m_open[m] = 1'b0; m_ref[m] = '0; m_age[m] = 0;
        e_cls[m] = 0; e_fch[m] = 0; e_fns[m] = 0; e_fxz[m] = 0; e_crs[m] = 0;
      end else if (enable !== 1'b1) begin
        e_cls[m] = 0; e_fch[m] = 0; e_fns[m] = 0; e_fxz[m] = 0; e_crs[m] = 0;
      end else begin
        xs = (xzcheck_enable === 1'b1) && $isunknown(start_event);
        xe = (xzcheck_enable === 1'b1) && $isunknown(test_expr);
        s  = (start_event === 1'b1) && !xs;
        e_cls[m] = 0; e_fch[m] = 0; e_fns[m] = 0; e_crs[m] = 0;
        e_fxz[m] = xs || (m_open[m] && xe);
        if (!m_open[m]) begin
          if (s) begin
            m_open[m] = 1'b1; m_ref[m] = test_expr; m_age[m] = 0;
          end
        end else begin
          m_age[m] = m_age[m] + 1;
          chg = !xe && ((test_expr != m_ref[m]) === 1'b1);
          if (chg || (m_age[m] == NCK)) begin
            e_cls[m]  = 1'b1;
            e_fch[m]  = !chg;
            m_open[m] = 1'b0;
            if (s && (m == 1)) begin
              m_open[m] = 1'b1; m_ref[m] = test_expr; m_age[m] = 0;
            end
          end else if (s) begin
            if (m == 1) begin
              m_ref[m] = test_expr; m_age[m] = 0; e_crs[m] = 1'b1;
            end
            if (m == 2) e_fns[m] = 1'b1;
          end
        end
      end
      e_win[m] = m_open[m];
    end
  endtask

  task automatic check(input string name, input int m, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s mode=%0d got=%b want=%b at %0t", name, m, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 3; m++) begin
      check("window", m, d_win[m], e_win[m]);
      check("window_close", m, d_cls[m], e_cls[m]);
      check("fire_change", m, d_fch[m], e_fch[m]);
      check("fire_new_start", m, d_fns[m], e_fns[m]);
      check("fire_xz", m, d_fxz[m], e_fxz[m]);
      check("cover_restart", m, d_crs[m], e_crs[m]);
    end
  endtask

  // Drive one cycle away from the edge, advance the model, then compare after the edge.
  task automatic cyc(input logic r, input logic e, input logic s, input logic [W-1:0] te,
                     input logic xz);
    reset = r; enable = e; start_event = s; test_expr = te; xzcheck_enable = xz;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);
  endtask

  logic [W-1:0] tv;
  logic [W-1:0] cur;

  initial begin
    reset = 1'b1; enable = 1'b1; start_event = 1'b0; test_expr = '0; xzcheck_enable = 1'b0;
    m_open = '0;
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int m = 0; m < 3; m++) begin
      check("reset_window", m, d_win[m], 1'b0);
      check("reset_close", m, d_cls[m], 1'b0);
      check("decode_ignore", m, d_ign[m], m == 0);
      check("decode_reset", m, d_rst[m], m == 1);
      check("decode_error", m, d_err[m], m == 2);
    end
    idle();

    // Basic change at T+2
    cyc(0, 1, 1, 8'h5A, 0);
    check("basic_win_t1", 0, d_win[0], 1'b1);
    cyc(0, 1, 0, 8'h5A, 0);
    check("basic_win_t2", 0, d_win[0], 1'b1);
    cyc(0, 1, 0, 8'h5B, 0);
    for (int m = 0; m < 3; m++) begin
      check("basic_close_t3", m, d_cls[m], 1'b1);
      check("basic_win_t3", m, d_win[m], 1'b0);
      check("basic_nofire_t3", m, d_fch[m], 1'b0);
    end
    idle();

    // Timeout with test_expr held
    cyc(0, 1, 1, 8'h5A, 0);
    repeat (2) cyc(0, 1, 0, 8'h5A, 0);
    check("to_nofire_t3", 0, d_fch[0], 1'b0);
    cyc(0, 1, 0, 8'h5A, 0);
    check("to_fire_t4", 0, d_fch[0], 1'b1);
    check("to_close_t4", 0, d_cls[0], 1'b1);
    check("to_win_t4", 0, d_win[0], 1'b0);
    idle();

    // Change in the last window cycle
    cyc(0, 1, 1, 8'h5A, 0);
    repeat (2) cyc(0, 1, 0, 8'h5A, 0);
    cyc(0, 1, 0, 8'h5B, 0);
    check("last_close_t4", 0, d_cls[0], 1'b1);
    check("last_nofire_t4", 0, d_fch[0], 1'b0);
    idle();

    // Second start at T+2: RESET restarts, ERROR flags
    cyc(0, 1, 1, 8'h5A, 0);
    cyc(0, 1, 0, 8'h5A, 0);
    cyc(0, 1, 1, 8'h5A, 0);
    check("rst_restart_t3", 1, d_crs[1], 1'b1);
    check("rst_win_t3", 1, d_win[1], 1'b1);
    check("rst_noclose_t3", 1, d_cls[1], 1'b0);
    check("err_fns_t3", 2, d_fns[2], 1'b1);
    cyc(0, 1, 0, 8'h5A, 0);
    check("ign_fire_t4", 0, d_fch[0], 1'b1);
    cyc(0, 1, 0, 8'h5A, 0);
    check("rst_nofire_t5", 1, d_fch[1], 1'b0);
    cyc(0, 1, 0, 8'h5A, 0);
    check("rst_fire_t6", 1, d_fch[1], 1'b1);
    idle();

    // ERROR mode start at T+1
    cyc(0, 1, 1, 8'h5A, 0);
    cyc(0, 1, 1, 8'h5A, 0);
    check("err_fns_t2", 2, d_fns[2], 1'b1);
    check("err_win_t2", 2, d_win[2], 1'b1);
    repeat (2) cyc(0, 1, 0, 8'h5A, 0);
    check("err_fire_t4", 2, d_fch[2], 1'b1);
    idle();

    // Start coincident with timeout
    cyc(0, 1, 1, 8'h5A, 0);
    repeat (2) cyc(0, 1, 0, 8'h5A, 0);
    cyc(0, 1, 1, 8'h5A, 0);
    check("coin_rst_close", 1, d_cls[1], 1'b1);
    check("coin_rst_fire", 1, d_fch[1], 1'b1);
    check("coin_rst_win", 1, d_win[1], 1'b1);
    check("coin_err_nofns", 2, d_fns[2], 1'b0);
    check("coin_err_win", 2, d_win[2], 1'b0);
    idle();

    // Reset mid-window
    cyc(0, 1, 1, 8'h5A, 0);
    cyc(0, 1, 0, 8'h5A, 0);
    cyc(1, 1, 0, 8'h5A, 0);
    for (int m = 0; m < 3; m++) begin
      check("midrst_win", m, d_win[m], 1'b0);
      check("midrst_close", m, d_cls[m], 1'b0);
    end
    idle();

    // Unknown test_expr while open
    tv = 8'hxx;
    cyc(0, 1, 1, 8'h5A, 1);
    cyc(0, 1, 0, tv, 1);
    check("xz_fire", 0, d_fxz[0], $isunknown(tv));
    idle();

    // Enable low for two cycles delays the timeout by two cycles
    cyc(0, 1, 1, 8'h5A, 0);
    cyc(0, 1, 0, 8'h5A, 0);
    cyc(0, 0, 0, 8'h5A, 0);
    cyc(0, 0, 0, 8'h5A, 0);
    check("en_win_hold", 0, d_win[0], 1'b1);
    cyc(0, 1, 0, 8'h5A, 0);
    check("en_nofire_t5", 0, d_fch[0], 1'b0);
    cyc(0, 1, 0, 8'h5A, 0);
    check("en_fire_t6", 0, d_fch[0], 1'b1);
    idle();

    // Randomized traffic against the model
    cur = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) cur = 8'($urandom_range(0, 3));
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 3) == 0), cur, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
